// File: rtl/ram_sched_pkg.sv
// Shared types and packet layout for the RAM-side request scheduler and the processor-side
// packet builder.
package ram_sched_pkg;

  localparam int unsigned RAM_DATA_W = 32;
  localparam int unsigned RAM_ADDR_W = 8;

  // Packet layout: {we, addr, wdata}, wdata in the low bits.
  localparam int unsigned PKT_WDATA_LSB = 0;
  localparam int unsigned PKT_ADDR_LSB  = RAM_DATA_W;
  localparam int unsigned PKT_WE_BIT    = RAM_ADDR_W + RAM_DATA_W;
  localparam int unsigned RAM_PKT_W     = 1 + RAM_ADDR_W + RAM_DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    EXEC,
    RDWAIT,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

  function automatic int unsigned pkt_width(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; the caller owns the last-grant register and commits the
// returned next value.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       advance_i,
  output logic       grant_o,
  output logic       last_grant_next_o
);

  always_comb begin
    unique case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      // Tie (and the don't-care no-request case) goes to the requester not served last.
      default: grant_o = ~last_grant_i;
    endcase
    last_grant_next_o = advance_i ? grant_o : last_grant_i;
  end

endmodule

// File: rtl/ram_req_scheduler.sv
// RAM-side request scheduler: pops request packets from two FIFOs round-robin, sequences a
// single-port RAM and pushes read data into the granted requester's response FIFO.
module ram_req_scheduler
  import ram_sched_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  localparam int unsigned PKT_W = pkt_width(ADDR_W, DATA_W)
) (
  input  logic                  ram_clk,
  input  logic                  reset,
  input  logic                  ram_enable,
  input  logic [1:0]            rq_empty,
  input  logic [1:0][PKT_W-1:0] rq_read_data,
  output logic [1:0]            rq_r_en,
  input  logic [1:0]            rsp_full,
  output logic [1:0]            rsp_w_en,
  output logic [DATA_W-1:0]     rsp_write_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  sched_state_t      state_q;
  logic              last_grant_q;
  logic              grant_q;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [DATA_W-1:0] rsp_q;
  logic              ram_en_q;
  logic              ram_we_q;

  logic              start;
  logic              arb_grant;
  logic              last_grant_d;
  logic [PKT_W-1:0]  pkt;

  // Gated by reset so no pop is requested while the block is held in reset.
  assign start = reset && (state_q == IDLE) && ram_enable && (rq_empty != 2'b11);
  assign pkt   = rq_read_data[grant_q];

  rr_arbiter_2 u_arb (
    .req_i             (~rq_empty),
    .last_grant_i      (last_grant_q),
    .advance_i         (start),
    .grant_o           (arb_grant),
    .last_grant_next_o (last_grant_d)
  );

  always_ff @(posedge ram_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      rsp_q        <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
    end else begin
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      last_grant_q <= last_grant_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            grant_q <= arb_grant;
            state_q <= LATCH;
          end
        end
        LATCH: begin
          req_we_q    <= pkt[PKT_W-1];
          req_addr_q  <= pkt[DATA_W +: ADDR_W];
          req_wdata_q <= pkt[DATA_W-1:0];
          ram_en_q    <= 1'b1;
          ram_we_q    <= pkt[PKT_W-1];
          state_q     <= EXEC;
        end
        EXEC:   state_q <= req_we_q ? IDLE : RDWAIT;
        RDWAIT: begin
          rsp_q   <= ram_rdata;
          state_q <= RESP;
        end
        RESP: begin
          if (!rsp_full[grant_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rq_r_en  = 2'b00;
    rsp_w_en = 2'b00;
    if (start) rq_r_en[arb_grant] = 1'b1;
    if ((state_q == RESP) && !rsp_full[grant_q]) rsp_w_en[grant_q] = 1'b1;
  end

  assign rsp_write_data = rsp_q;
  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = req_addr_q;
  assign ram_wdata      = req_wdata_q;
  assign busy           = (state_q != IDLE);
  assign grant_id       = grant_q;

endmodule
